// File: rtl/pixel_pair_unpack_pkg.sv
// Shared definitions for the pixel pair unpacker: word/pixel widths,
// channel field offsets, FSM state encoding and expansion-mode constants.
package pixel_pair_unpack_pkg;

  // Input channel width (fixed) and expanded output channel width
  localparam int CHAN_W     = 6;
  localparam int OUT_CHAN_W = 8;
  localparam int PAD_W      = OUT_CHAN_W - CHAN_W;

  // One packed pixel, a pair word, and one expanded RGB pixel
  localparam int PIX18_W = 3 * CHAN_W;
  localparam int PAIR_W  = 2 * PIX18_W;
  localparam int RGB24_W = 3 * OUT_CHAN_W;

  // Channel field offsets inside an 18-bit pixel {R,G,B}
  localparam int R_LSB = 12;
  localparam int G_LSB = 6;
  localparam int B_LSB = 0;

  // Expansion policy for the low bits of each output channel
  localparam int EXPAND_ZERO = 0;  // {c, 2'b00}
  localparam int EXPAND_REP  = 1;  // {c, c[5:4]}

  // EMPTY: no word held; LO: presenting pixel0; HI: presenting pixel1
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LO    = 2'd1,
    HI    = 2'd2
  } state_e;

  // Pull one 6-bit channel out of an 18-bit pixel at the given field offset
  function automatic logic [CHAN_W-1:0] get_chan(input logic [PIX18_W-1:0] pix,
                                                 input int unsigned lsb);
    get_chan = pix[lsb +: CHAN_W];
  endfunction

endpackage

// File: rtl/pixel_pair_unpack_if.sv
// Input-word and output-pixel handshake bundle for the pair unpacker.
//
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid and ready are both 1. A source holding valid=1 keeps its payload
// stable until the transfer; ready may depend combinationally on the
// partner's signals, valid never depends on ready.
interface pixel_pair_unpack_if;
  import pixel_pair_unpack_pkg::*;

  logic [PAIR_W-1:0]  in_word;
  logic               in_valid;
  logic               in_ready;
  logic [RGB24_W-1:0] out_pix;
  logic               out_valid;
  logic               out_ready;
  logic               out_first;

  // Upstream word source plus downstream pixel sink, as seen by the bench
  modport master (
    output in_word, in_valid, out_ready,
    input  in_ready, out_pix, out_valid, out_first
  );

  // The unpacker itself
  modport slave (
    input  in_word, in_valid, out_ready,
    output in_ready, out_pix, out_valid, out_first
  );

endinterface

// File: rtl/pixel_pair_unpack_chan_expand.sv
// Widens one 6-bit colour channel to 8 bits, either by zero-padding the
// LSBs or by replicating the top bits so full scale maps to full scale.
module pixel_pair_unpack_chan_expand
  import pixel_pair_unpack_pkg::*;
#(
  parameter int EXPAND_MODE = EXPAND_ZERO
) (
  input  logic [CHAN_W-1:0]     i_chan,
  output logic [OUT_CHAN_W-1:0] o_chan
);

  // Mode is a build-time choice, so only one of the two forms is elaborated
  generate
    if (EXPAND_MODE == EXPAND_REP) begin : g_rep
      assign o_chan = {i_chan, i_chan[CHAN_W-1 -: PAD_W]};
    end else begin : g_zero
      assign o_chan = {i_chan, {PAD_W{1'b0}}};
    end
  endgenerate

endmodule

// File: rtl/pixel_pair_unpack.sv
// Splits 36-bit two-pixel words into a stream of 24-bit RGB pixels, low
// pixel first, at one pixel per clock. The held word and the FSM state are
// the only storage; every output is decoded from those registers, so there
// is no combinational path from in_* to out_*. Only in_ready looks at the
// live out_ready/flush inputs, which is what allows a new word to be
// taken in the same cycle the previous pixel1 leaves (no bubble).
module pixel_pair_unpack
  import pixel_pair_unpack_pkg::*;
#(
  parameter int EXPAND_MODE = EXPAND_ZERO
) (
  input  logic                 clk,
  input  logic                 reset,        // asynchronous, active low
  input  logic                 flush,        // synchronous frame abort
  pixel_pair_unpack_if.slave   bus,
  output state_e               o_dbg_state
);

  state_e              r_state;
  logic [PAIR_W-1:0]   r_word;

  logic                w_in_ready;
  logic                w_accept;
  logic [PIX18_W-1:0]  w_pix18;
  logic [CHAN_W-1:0]   w_r6;
  logic [CHAN_W-1:0]   w_g6;
  logic [CHAN_W-1:0]   w_b6;
  logic [OUT_CHAN_W-1:0] w_r8;
  logic [OUT_CHAN_W-1:0] w_g8;
  logic [OUT_CHAN_W-1:0] w_b8;

  // A word can enter when nothing is held, or when pixel1 is leaving this
  // cycle. Held low during reset and during a flush cycle.
  assign w_in_ready = reset && !flush &&
                      ((r_state == EMPTY) || ((r_state == HI) && bus.out_ready));
  assign w_accept   = bus.in_valid && w_in_ready;

  // Word register and pixel-select FSM; flush wins over accept and out_ready
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= EMPTY;
      r_word  <= '0;
    end else if (flush) begin
      r_state <= EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_word  <= bus.in_word;
            r_state <= LO;
          end
        end
        LO: begin
          if (bus.out_ready) begin
            r_state <= HI;
          end
        end
        HI: begin
          if (bus.out_ready) begin
            if (w_accept) begin
              r_word  <= bus.in_word;
              r_state <= LO;
            end else begin
              r_state <= EMPTY;
            end
          end
        end
        default: begin
          r_state <= EMPTY;
        end
      endcase
    end
  end

  // Pick the half of the held word being presented, then split its channels
  always_comb begin
    w_pix18 = (r_state == HI) ? r_word[PAIR_W-1:PIX18_W] : r_word[PIX18_W-1:0];
    w_r6    = get_chan(w_pix18, R_LSB);
    w_g6    = get_chan(w_pix18, G_LSB);
    w_b6    = get_chan(w_pix18, B_LSB);
  end

  pixel_pair_unpack_chan_expand #(.EXPAND_MODE(EXPAND_MODE)) u_exp_r (
    .i_chan (w_r6),
    .o_chan (w_r8)
  );

  pixel_pair_unpack_chan_expand #(.EXPAND_MODE(EXPAND_MODE)) u_exp_g (
    .i_chan (w_g6),
    .o_chan (w_g8)
  );

  pixel_pair_unpack_chan_expand #(.EXPAND_MODE(EXPAND_MODE)) u_exp_b (
    .i_chan (w_b6),
    .o_chan (w_b8)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state != EMPTY);
  assign bus.out_first = (r_state != HI);
  assign bus.out_pix   = {w_r8, w_g8, w_b8};
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_pixel_pair_unpack.sv
// Directed bench for pixel_pair_unpack: zero-pad instance with a pixel
// scoreboard, plus a replicate-mode instance checked against constants.
module tb_pixel_pair_unpack;
  import pixel_pair_unpack_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush0 = 1'b0;
  logic flush1 = 1'b0;
  state_e dbg0;
  state_e dbg1;

  always #5 clk = ~clk;

  pixel_pair_unpack_if bus0 ();
  pixel_pair_unpack_if bus1 ();

  pixel_pair_unpack #(.EXPAND_MODE(EXPAND_ZERO)) u_dut0 (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush0),
    .bus         (bus0.slave),
    .o_dbg_state (dbg0)
  );

  pixel_pair_unpack #(.EXPAND_MODE(EXPAND_REP)) u_dut1 (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush1),
    .bus         (bus1.slave),
    .o_dbg_state (dbg1)
  );

  // ---------------- scoreboard ----------------
  logic [24:0] exp_q[$];   // {first, pix}
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [23:0] exp_pix(input logic [17:0] p, input bit rep);
    logic [5:0] r, g, b;
    r = p[17:12];
    g = p[11:6];
    b = p[5:0];
    if (rep) exp_pix = {r, r[5:4], g, g[5:4], b, b[5:4]};
    else     exp_pix = {r, 2'b00, g, 2'b00, b, 2'b00};
  endfunction

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sampled on the falling edge: pop on pixel handshake, drop on flush,
  // push both pixels of a word on input handshake.
  task automatic monitor();
    logic [24:0] e;
    logic [35:0] w;
    if (bus0.out_valid && bus0.out_ready) begin
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL sb_unexpected: observed pixel %h, expected no pixel", bus0.out_pix);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_pixel", {11'b0, bus0.out_first, bus0.out_pix}, {11'b0, e});
      end
    end
    if (flush0) exp_q.delete();
    if (bus0.in_valid && bus0.in_ready) begin
      w = bus0.in_word;
      exp_q.push_back({1'b1, exp_pix(w[17:0], 1'b0)});
      exp_q.push_back({1'b0, exp_pix(w[35:18], 1'b0)});
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  // Watchdog: the sequence below is fixed-length, this only guards a hang
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected summary before 200000");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  logic [35:0] words[8];
  logic [35:0] w4, w5, w6, w7, w8;

  initial begin
    bus0.in_word = '0; bus0.in_valid = 1'b0; bus0.out_ready = 1'b0;
    bus1.in_word = '0; bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) words[i] = {$urandom_range(0, 15), $urandom};
    w4 = {$urandom_range(0, 15), $urandom};
    w5 = {$urandom_range(0, 15), $urandom};
    w6 = {$urandom_range(0, 15), $urandom};
    w7 = {$urandom_range(0, 15), $urandom};
    w8 = {$urandom_range(0, 15), $urandom};

    // Reset values
    tick(); tick();
    chk("rst_in_ready",  36'(bus0.in_ready),  36'd0);
    chk("rst_out_valid", 36'(bus0.out_valid), 36'd0);
    chk("rst_out_first", 36'(bus0.out_first), 36'd1);
    chk("rst_out_pix",   36'(bus0.out_pix),   36'd0);
    reset = 1'b1;
    tick();
    chk("idle_state", 36'(dbg0), 36'(EMPTY));

    // Single word, zero-pad expansion
    bus0.in_word = {18'h3F000, 18'h00FFF};
    bus0.in_valid = 1'b1; bus0.out_ready = 1'b1;
    #1;
    chk("single_in_ready", 36'(bus0.in_ready), 36'd1);
    tick();
    bus0.in_valid = 1'b0;
    chk("single_pix0",   36'(bus0.out_pix),   36'h00FCFC);
    chk("single_first0", 36'(bus0.out_first), 36'd1);
    tick();
    chk("single_pix1",   36'(bus0.out_pix),   36'hFC0000);
    chk("single_first1", 36'(bus0.out_first), 36'd0);
    tick();
    chk("single_done", 36'(bus0.out_valid), 36'd0);

    // Streaming: 8 words back to back
    for (int c = 0; c < 16; c++) begin
      bus0.in_word  = words[c / 2];
      bus0.in_valid = (c % 2 == 0);
      #1;
      chk("stream_in_ready", 36'(bus0.in_ready), 36'((c % 2) == 0));
      tick();
      chk("stream_out_valid", 36'(bus0.out_valid), 36'd1);
    end
    bus0.in_valid = 1'b0;
    tick();
    chk("stream_end_valid", 36'(bus0.out_valid), 36'd0);
    chk("stream_drained", 36'(exp_q.size()), 36'd0);

    // Backpressure in LO then in HI
    bus0.in_word = w4; bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0; bus0.out_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_lo_pix",      36'(bus0.out_pix),   36'(exp_pix(w4[17:0], 1'b0)));
      chk("bp_lo_first",    36'(bus0.out_first), 36'd1);
      chk("bp_lo_in_ready", 36'(bus0.in_ready),  36'd0);
      tick();
    end
    bus0.out_ready = 1'b1;
    tick();
    bus0.out_ready = 1'b0;
    bus0.in_word = w5; bus0.in_valid = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_hi_pix",      36'(bus0.out_pix),   36'(exp_pix(w4[35:18], 1'b0)));
      chk("bp_hi_first",    36'(bus0.out_first), 36'd0);
      chk("bp_hi_in_ready", 36'(bus0.in_ready),  36'd0);
      tick();
    end
    bus0.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 36'(bus0.in_ready), 36'd1);
    tick();
    bus0.in_valid = 1'b0;
    tick();
    tick();
    chk("bp_end_valid", 36'(bus0.out_valid), 36'd0);
    chk("bp_drained", 36'(exp_q.size()), 36'd0);

    // Flush while presenting pixel0, with a new word offered
    bus0.in_word = w6; bus0.in_valid = 1'b1;
    tick();
    bus0.in_word = w7; flush0 = 1'b1;
    #1;
    chk("flush_in_ready", 36'(bus0.in_ready), 36'd0);
    tick();
    flush0 = 1'b0; bus0.in_valid = 1'b0;
    #1;
    chk("flush_state",     36'(dbg0),           36'(EMPTY));
    chk("flush_out_valid", 36'(bus0.out_valid), 36'd0);
    tick(); tick();
    chk("flush_quiet", 36'(bus0.out_valid), 36'd0);
    chk("flush_q_empty", 36'(exp_q.size()), 36'd0);

    // Asynchronous reset in the middle of a pair
    bus0.in_word = w8; bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0; bus0.out_ready = 1'b0;
    chk("pre_rst_valid", 36'(bus0.out_valid), 36'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", 36'(bus0.out_valid), 36'd0);
    chk("mid_rst_in_ready",  36'(bus0.in_ready),  36'd0);
    chk("mid_rst_out_first", 36'(bus0.out_first), 36'd1);
    chk("mid_rst_out_pix",   36'(bus0.out_pix),   36'd0);
    exp_q.delete();
    tick();
    reset = 1'b1;
    bus0.out_ready = 1'b1;
    tick();
    chk("post_rst_valid", 36'(bus0.out_valid), 36'd0);

    // Replicate-mode instance
    bus1.in_word = {18'h01FE0, 18'h3F801};
    bus1.in_valid = 1'b1; bus1.out_ready = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    chk("rep_pix0",   36'(bus1.out_pix),   36'hFF8204);
    chk("rep_first0", 36'(bus1.out_first), 36'd1);
    tick();
    chk("rep_pix1",   36'(bus1.out_pix),   36'h04FF82);
    chk("rep_first1", 36'(bus1.out_first), 36'd0);
    tick();
    chk("rep_done", 36'(bus1.out_valid), 36'd0);
    chk("rep_state", 36'(dbg1), 36'(EMPTY));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
